// File: rtl/onehot_capture_fifo.sv
// Checks one-hot / all-zero decoder lines, re-encodes them to an index
// and buffers the results in a small FWFT FIFO; multi-hot words are counted.
module onehot_capture_fifo #(
    parameter int IDX_W = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8,
    localparam int N     = 1 << IDX_W,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     y_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_zero,
    output logic [LVL_W-1:0] level,
    output logic             err_multi,
    output logic [CNT_W-1:0] err_count,
    input  logic             err_clr
);

    logic [IDX_W-1:0] mem_idx_q [DEPTH];
    logic             mem_zero_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic [IDX_W-1:0] hold_idx_q;
    logic             hold_zero_q;
    logic             err_multi_q, err_multi_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic             acc, push, pop, is_multi, is_zero;
    logic [IDX_W-1:0] enc_idx;

    assign in_ready  = (level_q != LVL_W'(DEPTH));
    assign out_valid = (level_q != '0);
    assign acc       = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // A word is multi-hot iff clearing its lowest set bit leaves something.
    assign is_multi  = |(y_in & (y_in - N'(1)));
    assign is_zero   = (y_in == '0);
    assign push      = acc & ~is_multi;

    always_comb begin
        enc_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (y_in[i]) enc_idx = enc_idx | IDX_W'(i);
        end
    end

    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Clear takes effect first, so a same-cycle multi-hot word still counts.
    always_comb begin
        err_multi_d = err_multi_q;
        err_count_d = err_count_q;
        if (err_clr) begin
            err_multi_d = 1'b0;
            err_count_d = '0;
        end
        if (acc && is_multi) begin
            err_multi_d = 1'b1;
            if (err_count_d != '1) err_count_d = err_count_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_idx_q[i]  <= '0;
                mem_zero_q[i] <= 1'b0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            hold_idx_q  <= '0;
            hold_zero_q <= 1'b0;
            err_multi_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            if (push) begin
                mem_idx_q[wr_ptr_q]  <= is_zero ? '0 : enc_idx;
                mem_zero_q[wr_ptr_q] <= is_zero;
                wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q     <= level_d;
            hold_idx_q  <= out_idx;
            hold_zero_q <= out_zero;
            err_multi_q <= err_multi_d;
            err_count_q <= err_count_d;
        end
    end

    // When empty, keep showing whatever the consumer last saw.
    assign out_idx   = out_valid ? mem_idx_q[rd_ptr_q]  : hold_idx_q;
    assign out_zero  = out_valid ? mem_zero_q[rd_ptr_q] : hold_zero_q;
    assign level     = level_q;
    assign err_multi = err_multi_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_onehot_capture_fifo.sv
// Directed bench for onehot_capture_fifo: inputs change 1ns after the
// rising edge, outputs are checked at that same point.
module tb_onehot_capture_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] y_in;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_idx;
    logic        out_zero;
    logic [2:0]  level;
    logic        err_multi;
    logic [7:0]  err_count;
    logic        err_clr;

    int n_chk  = 0;
    int n_pass = 0;
    int expq[$];

    onehot_capture_fifo dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_zero  (out_zero),
        .level     (level),
        .err_multi (err_multi),
        .err_count (err_count),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; y_in = '0;
        out_ready = 1'b0; err_clr = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_level", int'(level), 0);
        chk("rst_oval", int'(out_valid), 0);
        chk("rst_irdy", int'(in_ready), 1);
        chk("rst_idx", int'(out_idx), 0);
        chk("rst_zero", int'(out_zero), 0);
        chk("rst_emul", int'(err_multi), 0);
        chk("rst_ecnt", int'(err_count), 0);

        // 1: walking one, push and pop every cycle
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1;
            y_in = 16'(1) << k;
            tick();
            chk("t1_oval", int'(out_valid), 1);
            chk("t1_idx", int'(out_idx), k);
            chk("t1_zero", int'(out_zero), 0);
            chk("t1_level", int'(level), 1);
        end
        in_valid = 1'b0;
        tick();
        chk("t1_drain", int'(level), 0);
        chk("t1_ecnt", int'(err_count), 0);

        // 2: all-zero word
        in_valid = 1'b1; y_in = 16'h0000;
        tick();
        in_valid = 1'b0;
        chk("t2_level1", int'(level), 1);
        chk("t2_zero", int'(out_zero), 1);
        chk("t2_idx", int'(out_idx), 0);
        tick();
        chk("t2_level0", int'(level), 0);
        chk("t2_oval", int'(out_valid), 0);

        // 3: multi-hot words and error clear
        in_valid = 1'b1; y_in = 16'h0011;
        tick();
        chk("t3_ecnt1", int'(err_count), 1);
        chk("t3_level", int'(level), 0);
        y_in = 16'hFFFF;
        tick();
        chk("t3_emul", int'(err_multi), 1);
        chk("t3_ecnt2", int'(err_count), 2);
        chk("t3_nopush", int'(level), 0);
        in_valid = 1'b0; err_clr = 1'b1;
        tick();
        chk("t3_clr_mul", int'(err_multi), 0);
        chk("t3_clr_cnt", int'(err_count), 0);
        in_valid = 1'b1; y_in = 16'h0003;
        tick();
        in_valid = 1'b0; err_clr = 1'b0;
        chk("t3_cc_mul", int'(err_multi), 1);
        chk("t3_cc_cnt", int'(err_count), 1);
        chk("t3_cc_lvl", int'(level), 0);

        // 4: fill to full, refuse a fifth, drain in order
        out_ready = 1'b0; err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        expq = '{3, 7, 9, 15};
        foreach (expq[i]) begin
            in_valid = 1'b1;
            y_in = 16'(1) << expq[i];
            tick();
        end
        chk("t4_level", int'(level), 4);
        chk("t4_irdy", int'(in_ready), 0);
        y_in = 16'(1) << 5;
        tick();
        in_valid = 1'b0;
        chk("t4_nofifth", int'(level), 4);
        out_ready = 1'b1;
        foreach (expq[i]) begin
            chk("t4_order", int'(out_idx), expq[i]);
            tick();
        end
        chk("t4_empty", int'(out_valid), 0);
        chk("t4_hold", int'(out_idx), 15);
        chk("t4_lvl0", int'(level), 0);

        // 5: steady push+pop at level 2, pointers wrap
        out_ready = 1'b0;
        expq = '{1, 2};
        foreach (expq[i]) begin
            in_valid = 1'b1;
            y_in = 16'(1) << expq[i];
            tick();
        end
        chk("t5_level", int'(level), 2);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            int v;
            v = (i * 5 + 4) % 16;
            y_in = 16'(1) << v;
            chk("t5_head", int'(out_idx), expq[0]);
            void'(expq.pop_front());
            expq.push_back(v);
            tick();
            chk("t5_steady", int'(level), 2);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("t5_tail", int'(out_idx), expq[0]);
            void'(expq.pop_front());
            tick();
        end
        chk("t5_empty", int'(level), 0);

        // 6: reset with three entries held and an error flagged
        out_ready = 1'b0;
        in_valid = 1'b1; y_in = 16'h00F0;
        tick();
        for (int i = 0; i < 3; i++) begin
            y_in = 16'(1) << (i + 10);
            tick();
        end
        in_valid = 1'b0;
        chk("t6_pre_lvl", int'(level), 3);
        chk("t6_pre_err", int'(err_multi), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t6_level", int'(level), 0);
        chk("t6_oval", int'(out_valid), 0);
        chk("t6_irdy", int'(in_ready), 1);
        chk("t6_emul", int'(err_multi), 0);
        chk("t6_ecnt", int'(err_count), 0);
        chk("t6_idx", int'(out_idx), 0);
        out_ready = 1'b1;
        tick();
        chk("t6_nostale", int'(out_valid), 0);
        in_valid = 1'b1; y_in = 16'(1) << 6;
        tick();
        in_valid = 1'b0;
        chk("t6_new_idx", int'(out_idx), 6);
        chk("t6_new_lvl", int'(level), 1);
        tick();
        chk("t6_done", int'(out_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
